commit_trace_buffer: RTL and testbench

Retire-side capture stage that sits between the processor's writeback stage and the simulation trace/log consumer. Each cycle it takes one retiring instruction's commit information, classifies it, tags it with a sequential instruction number, and queues it in a small FIFO. The consumer drains records with a valid/ready handshake. The block also maintains the cycle and instruction counters and signals completion once a halt has retired and the queue is drained.

---
 rtl/trace_pkg.sv | 50 +++++
 rtl/commit_trace_buffer_if.sv | 51 +++++
 rtl/trace_fifo.sv | 56 +++++
 rtl/commit_trace_buffer.sv | 112 +++++++++++
 tb/tb_commit_trace_buffer.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// ============================================================================
// Module      : trace_pkg
// Description : Shared record, kind and state types for the commit trace buffer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package trace_pkg;

  // Stored inum width; a wider CNT_W zero-extends, a narrower one truncates.
  localparam int c_INUM_W = 32;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    REG  = 3'd1,
    LD   = 3'd2,
    ST   = 3'd3,
    STU  = 3'd4,
    HALT = 3'd5
  } rec_kind_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    rec_kind_t             kind;
    logic [c_INUM_W-1:0]   inum;
    logic [15:0]           pc;
    logic [2:0]            reg_sel;
    logic [15:0]           reg_data;
    logic [15:0]           mem_addr;
    logic [15:0]           mem_data;
  } trace_rec_t;

  function automatic rec_kind_t classify(input logic halt, input logic reg_we,
                                         input logic mem_re, input logic mem_we);
    if (halt)              return HALT;
    if (reg_we && mem_we)  return STU;
    if (reg_we && mem_re)  return LD;
    if (reg_we)            return REG;
    if (mem_we)            return ST;
    return NOP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/commit_trace_buffer_if.sv
// ============================================================================
// Module      : commit_trace_buffer_if
// Description : Commit input, record output and status bundle of the trace buffer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface commit_trace_buffer_if #(
  parameter int CNT_W = 32
);
  logic              commit_valid;
  logic [15:0]       commit_pc;
  logic [15:0]       commit_inst;
  logic              reg_we;
  logic [2:0]        reg_sel;
  logic [15:0]       reg_data;
  logic              mem_re;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [15:0]       mem_wdata;
  logic              halt;
  logic              rec_ready;
  logic              rec_valid;
  logic [2:0]        rec_kind;
  logic [CNT_W-1:0]  rec_inum;
  logic [15:0]       rec_pc;
  logic [2:0]        rec_reg_sel;
  logic [15:0]       rec_reg_data;
  logic [15:0]       rec_mem_addr;
  logic [15:0]       rec_mem_data;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  inst_count;
  logic              overflow;
  logic              done;

  modport master (
    output commit_valid, commit_pc, commit_inst, reg_we, reg_sel, reg_data,
           mem_re, mem_we, mem_addr, mem_wdata, halt, rec_ready,
    input  rec_valid, rec_kind, rec_inum, rec_pc, rec_reg_sel, rec_reg_data,
           rec_mem_addr, rec_mem_data, cycle_count, inst_count, overflow, done
  );

  modport slave (
    input  commit_valid, commit_pc, commit_inst, reg_we, reg_sel, reg_data,
           mem_re, mem_we, mem_addr, mem_wdata, halt, rec_ready,
    output rec_valid, rec_kind, rec_inum, rec_pc, rec_reg_sel, rec_reg_data,
           rec_mem_addr, rec_mem_data, cycle_count, inst_count, overflow, done
  );
endinterface

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module      : trace_fifo
// Description : Show-ahead FIFO of trace records; pointers carry a wrap bit.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type REC_T = logic [7:0]
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   i_push,
  input  wire logic                   i_pop,
  input  wire REC_T                   i_data,
  output REC_T                        o_head,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [$clog2(DEPTH):0]      o_count
);
  localparam int c_AW = $clog2(DEPTH);

  REC_T             r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Storage is not reset; the empty mask keeps the head at zero instead.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// ============================================================================
// Module      : commit_trace_buffer
// Description : Classifies retiring instructions, numbers them and queues records.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  commit_trace_buffer_if.slave bus
);
  localparam int c_AW = $clog2(DEPTH);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_inst_count;
  logic              r_overflow;

  rec_kind_t         w_kind;
  trace_rec_t        w_rec;
  trace_rec_t        w_head;
  logic              w_full;
  logic              w_empty;
  logic [c_AW:0]     w_count;
  logic              w_pop;
  logic              w_accept;
  logic              w_push;
  logic              w_drop;
  logic              w_drained;
  logic              w_unused_inst;

  assign w_unused_inst = ^bus.commit_inst;

  assign w_kind = classify(bus.halt, bus.reg_we, bus.mem_re, bus.mem_we);

  // Fields that the record class does not use stay zero.
  always_comb begin
    w_rec      = '0;
    w_rec.kind = w_kind;
    w_rec.inum = c_INUM_W'(r_inst_count);
    w_rec.pc   = bus.commit_pc;
    if (w_kind inside {REG, LD, STU}) begin
      w_rec.reg_sel  = bus.reg_sel;
      w_rec.reg_data = bus.reg_data;
    end
    if (w_kind inside {LD, ST, STU}) w_rec.mem_addr = bus.mem_addr;
    if (w_kind inside {ST, STU})     w_rec.mem_data = bus.mem_wdata;
  end

  assign w_pop     = ~w_empty & bus.rec_ready;
  assign w_accept  = bus.commit_valid & (r_state == RUN);
  assign w_push    = w_accept & (~w_full | w_pop);
  assign w_drop    = w_accept & w_full & ~w_pop;
  assign w_drained = w_empty | (w_pop & (w_count == (c_AW+1)'(1)));

  trace_fifo #(
    .DEPTH (DEPTH),
    .REC_T (trace_rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_rec),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // A dropped commit still consumes an inum so the consumer sees the gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_cycle_count <= '0;
      r_inst_count  <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (r_state != DONE) r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_accept)        r_inst_count  <= r_inst_count + CNT_W'(1);
      if (w_drop)          r_overflow    <= 1'b1;
      case (r_state)
        RUN:     if (w_accept & bus.halt) r_state <= DRAIN;
        DRAIN:   if (w_drained)           r_state <= DONE;
        DONE:    r_state <= DONE;
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.rec_valid    = ~w_empty;
  assign bus.rec_kind     = w_head.kind;
  assign bus.rec_inum     = CNT_W'(w_head.inum);
  assign bus.rec_pc       = w_head.pc;
  assign bus.rec_reg_sel  = w_head.reg_sel;
  assign bus.rec_reg_data = w_head.reg_data;
  assign bus.rec_mem_addr = w_head.mem_addr;
  assign bus.rec_mem_data = w_head.mem_data;
  assign bus.cycle_count  = r_cycle_count;
  assign bus.inst_count   = r_inst_count;
  assign bus.overflow     = r_overflow;
  assign bus.done         = (r_state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Directed and random bench for commit_trace_buffer against a queue model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_buffer;
  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  commit_trace_buffer_if #(.CNT_W(CNT_W)) bus ();

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [15:0] pc;
    logic [2:0]  sel;
    logic [15:0] rdata;
    logic [15:0] maddr;
    logic [15:0] mdata;
  } mrec_t;

  mrec_t       q[$];
  mrec_t       m_new;
  mrec_t       m_exp;
  int          m_state;   // 0 run, 1 drain, 2 done
  logic [31:0] m_cyc;
  logic [31:0] m_inst;
  logic        m_ovf;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mrec_t make_rec(input logic [31:0] inum);
    mrec_t r;
    r = '{default: '0};
    if (bus.halt)                      r.kind = 3'd5;
    else if (bus.reg_we && bus.mem_we) r.kind = 3'd4;
    else if (bus.reg_we && bus.mem_re) r.kind = 3'd2;
    else if (bus.reg_we)               r.kind = 3'd1;
    else if (bus.mem_we)               r.kind = 3'd3;
    else                               r.kind = 3'd0;
    r.inum = inum;
    r.pc   = bus.commit_pc;
    if (r.kind == 3'd1 || r.kind == 3'd2 || r.kind == 3'd4) begin
      r.sel   = bus.reg_sel;
      r.rdata = bus.reg_data;
    end
    if (r.kind == 3'd2 || r.kind == 3'd3 || r.kind == 3'd4) r.maddr = bus.mem_addr;
    if (r.kind == 3'd3 || r.kind == 3'd4) r.mdata = bus.mem_wdata;
    return r;
  endfunction

  // Reference model: pop first, then a commit fits if the queue has room.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_state = 0;
      m_cyc   = 0;
      m_inst  = 0;
      m_ovf   = 1'b0;
    end else begin
      if (q.size() > 0 && bus.rec_ready) void'(q.pop_front());
      if (m_state != 2) m_cyc = m_cyc + 1;
      if (m_state == 0 && bus.commit_valid) begin
        m_new = make_rec(m_inst);
        if (q.size() < DEPTH) q.push_back(m_new);
        else m_ovf = 1'b1;
        m_inst = m_inst + 1;
        if (bus.halt) m_state = 1;
      end else if (m_state == 1 && q.size() == 0) begin
        m_state = 2;
      end
    end
  end

  always @(negedge clk) begin
    if (q.size() > 0) m_exp = q[0];
    else              m_exp = '{default: '0};
    chk("rec_valid",    bus.rec_valid,    q.size() > 0);
    chk("rec_kind",     bus.rec_kind,     m_exp.kind);
    chk("rec_inum",     bus.rec_inum,     m_exp.inum);
    chk("rec_pc",       bus.rec_pc,       m_exp.pc);
    chk("rec_reg_sel",  bus.rec_reg_sel,  m_exp.sel);
    chk("rec_reg_data", bus.rec_reg_data, m_exp.rdata);
    chk("rec_mem_addr", bus.rec_mem_addr, m_exp.maddr);
    chk("rec_mem_data", bus.rec_mem_data, m_exp.mdata);
    chk("cycle_count",  bus.cycle_count,  m_cyc);
    chk("inst_count",   bus.inst_count,   m_inst);
    chk("overflow",     bus.overflow,     m_ovf);
    chk("done",         bus.done,         m_state == 2);
  end

  task automatic drive(input bit v, input bit rwe, input bit mre, input bit mwe, input bit h,
                       input logic [15:0] pc, input logic [2:0] sel, input logic [15:0] rd,
                       input logic [15:0] ma, input logic [15:0] md);
    bus.commit_valid = v;
    bus.reg_we       = rwe;
    bus.mem_re       = mre;
    bus.mem_we       = mwe;
    bus.halt         = h;
    bus.commit_pc    = pc;
    bus.commit_inst  = pc ^ 16'h5A5A;
    bus.reg_sel      = sel;
    bus.reg_data     = rd;
    bus.mem_addr     = ma;
    bus.mem_wdata    = md;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 16'h0, 3'd0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic reg_commit(input logic [15:0] pc);
    drive(1, 1, 0, 0, 0, pc, 3'd1, pc + 16'h1000, 16'hFFFF, 16'hEEEE);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    bus.rec_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rec_valid", bus.rec_valid, 1'b0);
    chk("reset_cycle",     bus.cycle_count, 32'd0);
    chk("reset_done",      bus.done, 1'b0);
    chk("reset_rec_pc",    bus.rec_pc, 16'h0);
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ep_cycles;
    int rdy_lvl;
    bit h;

    // REG then STU then LD with a ready consumer.
    do_reset();
    bus.rec_ready = 1'b1;
    drive(1, 1, 0, 0, 0, 16'h0000, 3'd3, 16'h1234, 16'h0, 16'h0);
    step(); idle();
    chk("t1_valid", bus.rec_valid, 1'b1);
    chk("t1_kind",  bus.rec_kind, 3'd1);
    chk("t1_inum",  bus.rec_inum, 32'd0);
    chk("t1_sel",   bus.rec_reg_sel, 3'd3);
    chk("t1_data",  bus.rec_reg_data, 16'h1234);
    chk("t1_icnt",  bus.inst_count, 32'd1);
    chk("t1_cyc",   bus.cycle_count, 32'd1);
    drive(1, 1, 0, 1, 0, 16'h0002, 3'd5, 16'h0010, 16'h0010, 16'hBEEF);
    step(); idle();
    chk("stu_kind",  bus.rec_kind, 3'd4);
    chk("stu_inum",  bus.rec_inum, 32'd1);
    chk("stu_sel",   bus.rec_reg_sel, 3'd5);
    chk("stu_rdata", bus.rec_reg_data, 16'h0010);
    chk("stu_addr",  bus.rec_mem_addr, 16'h0010);
    chk("stu_mdata", bus.rec_mem_data, 16'hBEEF);
    drive(1, 1, 1, 0, 0, 16'h0004, 3'd2, 16'h0055, 16'h0020, 16'h7777);
    step(); idle();
    chk("ld_kind",  bus.rec_kind, 3'd2);
    chk("ld_inum",  bus.rec_inum, 32'd2);
    chk("ld_addr",  bus.rec_mem_addr, 16'h0020);
    chk("ld_mdata", bus.rec_mem_data, 16'h0000);

    // Overflow: DEPTH+2 commits with a stalled consumer, then drain.
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) begin
      reg_commit(16'(i)); step();
    end
    idle();
    chk("ovf_flag",  bus.overflow, 1'b1);
    chk("ovf_icnt",  bus.inst_count, 32'd10);
    chk("ovf_valid", bus.rec_valid, 1'b1);
    bus.rec_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_inum", bus.rec_inum, 32'(i));
      step();
    end
    chk("drain_empty", bus.rec_valid, 1'b0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      reg_commit(16'(i)); step();
    end
    chk("full_no_ovf", bus.overflow, 1'b0);
    bus.rec_ready = 1'b1;
    reg_commit(16'h0100); step();
    bus.rec_ready = 1'b0;
    chk("pp_no_ovf", bus.overflow, 1'b0);
    chk("pp_head",   bus.rec_inum, 32'd1);
    reg_commit(16'h0101); step(); idle();
    chk("pp_still_full", bus.overflow, 1'b1);

    // Halt sequence: HALT retires on cycle 5, later commits ignored.
    do_reset();
    bus.rec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reg_commit(16'(i * 2)); step();
    end
    idle(); step();
    drive(1, 0, 0, 0, 1, 16'h0040, 3'd0, 16'h0, 16'h0, 16'h0);
    step();
    chk("halt_kind", bus.rec_kind, 3'd5);
    chk("halt_inum", bus.rec_inum, 32'd3);
    chk("halt_pc",   bus.rec_pc, 16'h0040);
    chk("halt_done_early", bus.done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      reg_commit(16'h0050); step();
    end
    idle();
    chk("halt_icnt", bus.inst_count, 32'd4);
    chk("halt_done", bus.done, 1'b1);
    chk("halt_cyc",  bus.cycle_count, 32'd6);
    repeat (3) step();
    chk("frozen_cyc", bus.cycle_count, 32'd6);

    // HALT dropped by a full FIFO still enters DRAIN.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      reg_commit(16'(i)); step();
    end
    drive(1, 0, 0, 0, 1, 16'h0077, 3'd0, 16'h0, 16'h0, 16'h0);
    step(); idle();
    chk("hdrop_ovf",  bus.overflow, 1'b1);
    chk("hdrop_icnt", bus.inst_count, 32'd9);
    bus.rec_ready = 1'b1;
    repeat (DEPTH) step();
    chk("hdrop_done", bus.done, 1'b1);

    // Asynchronous reset in the middle of DRAIN.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      reg_commit(16'(i)); step();
    end
    drive(1, 0, 0, 0, 1, 16'h0030, 3'd0, 16'h0, 16'h0, 16'h0);
    step(); idle(); step();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", bus.rec_valid, 1'b0);
    chk("arst_icnt",  bus.inst_count, 32'd0);
    chk("arst_cyc",   bus.cycle_count, 32'd0);
    chk("arst_done",  bus.done, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    chk("arst_run_cyc", bus.cycle_count, 32'd1);
    chk("arst_run",     bus.done, 1'b0);

    // Random episodes, each ending with a HALT and a full drain.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset();
      rdy_lvl   = $urandom_range(1, 4);
      ep_cycles = 0;
      while (m_state != 2 && ep_cycles < 400) begin
        h = ($urandom_range(0, 59) == 0) || (ep_cycles >= 150);
        drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom), h,
              16'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        bus.rec_ready = ($urandom_range(0, 3) < rdy_lvl);
        step();
        ep_cycles++;
      end
      idle();
      chk("episode_done", bus.done, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
